row_clear_controller: RTL and testbench

- Sequences full-row clearing on the 8-wide x 20-tall Tetris board after a piece locks.
- Scans rows bottom-up through a row-wide read/write port on the board register and compacts non-full rows downward with a two-pointer scheme.
- Zero-fills the vacated top rows, counts cleared lines and maintains the saturating game score.
- Sits between the game FSM (start/done handshake) and the board storage. The game FSM drives start when it leaves COLLISION.

---
 rtl/tetris_pkg.sv | 32 +++
 rtl/score_accumulator.sv | 41 ++++
 rtl/row_clear_controller.sv | 132 +++++++++++++
 tb/tb_row_clear_controller.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared board geometry, row constants, one-hot controller states and the
// line-count to score-increment table.
package tetris_pkg;

  localparam int ROWS    = 20;
  localparam int COLS    = 8;
  localparam int ROW_AW  = 5;
  localparam int SCORE_W = 8;

  localparam logic [COLS-1:0] FULL_ROW  = 8'hFF;
  localparam logic [COLS-1:0] EMPTY_ROW = 8'h00;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_SCAN = 4'b0010,
    ST_FILL = 4'b0100,
    ST_DONE = 4'b1000
  } state_e;

  function automatic logic [3:0] score_increment(input int unsigned lines);
    logic [3:0] inc;
    case (lines)
      0:       inc = 4'd0;
      1:       inc = 4'd1;
      2:       inc = 4'd3;
      3:       inc = 4'd5;
      default: inc = 4'd8;
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/score_accumulator.sv
// Saturating game score: adds the increment for a finished clear pass,
// with a synchronous clear that overrides any same-cycle update.
module score_accumulator #(
  parameter int SCORE_W = 8,
  parameter int LINES_W = 5
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               clear_score,
  input  logic               update_en,
  input  logic [LINES_W-1:0] lines,
  output logic [SCORE_W-1:0] score
);
  import tetris_pkg::*;

  localparam int SUM_W = SCORE_W + 1;

  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W:0]   sum;

  always_comb begin
    sum     = {1'b0, score_q} + SUM_W'(score_increment(int'(lines)));
    score_d = score_q;
    if (clear_score) begin
      score_d = '0;
    end else if (update_en) begin
      score_d = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      score_q <= '0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score = score_q;

endmodule

// File: rtl/row_clear_controller.sv
// Clears full board rows after a piece locks: bottom-up scan compacting
// non-full rows downward, zero-fill of vacated top rows, line/score update.
//
// state | meaning
// IDLE  | waiting for start
// SCAN  | read row src, move it to dst unless full
// FILL  | write empty rows from dst to the top
// DONE  | pulse done, latch line count, update score
module row_clear_controller #(
  parameter int ROWS    = tetris_pkg::ROWS,
  parameter int COLS    = tetris_pkg::COLS,
  parameter int ROW_AW  = tetris_pkg::ROW_AW,
  parameter int SCORE_W = tetris_pkg::SCORE_W
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               start,
  input  logic               clear_score,
  output logic [ROW_AW-1:0]  rd_row,
  input  logic [COLS-1:0]    rd_data,
  output logic               wr_en,
  output logic [ROW_AW-1:0]  wr_row,
  output logic [COLS-1:0]    wr_data,
  output logic               busy,
  output logic               done,
  output logic [ROW_AW-1:0]  lines_cleared,
  output logic [SCORE_W-1:0] score
);
  import tetris_pkg::*;

  localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(ROWS - 1);
  localparam logic [ROW_AW:0]   ROWS_EXT = (ROW_AW + 1)'(ROWS);
  localparam logic [COLS-1:0]   ROW_ONES = '1;

  state_e            state_q, state_d;
  logic [ROW_AW-1:0] src_q, src_d;
  logic [ROW_AW-1:0] dst_q, dst_d;
  logic [ROW_AW-1:0] cnt_q, cnt_d;
  logic [ROW_AW-1:0] lines_q, lines_d;
  logic              row_full;

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    cnt_d    = cnt_q;
    lines_d  = lines_q;
    rd_row   = '0;
    wr_en    = 1'b0;
    wr_row   = '0;
    wr_data  = '0;
    busy     = 1'b0;
    done     = 1'b0;
    row_full = (rd_data == ROW_ONES);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SCAN;
          src_d   = '0;
          dst_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_SCAN: begin
        busy   = 1'b1;
        rd_row = src_q;
        if (row_full) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          // a row already in place needs no rewrite
          wr_en   = (dst_q != src_q);
          wr_row  = dst_q;
          wr_data = rd_data;
          dst_d   = dst_q + 1'b1;
        end
        src_d = src_q + 1'b1;
        if (src_q == LAST_ROW) begin
          state_d = ({1'b0, dst_d} < ROWS_EXT) ? ST_FILL : ST_DONE;
        end
      end
      ST_FILL: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_row  = dst_q;
        wr_data = EMPTY_ROW;
        dst_d   = dst_q + 1'b1;
        if (dst_q == LAST_ROW) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        lines_d = cnt_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      lines_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      lines_q <= lines_d;
    end
  end

  assign lines_cleared = lines_q;

  score_accumulator #(
    .SCORE_W (SCORE_W),
    .LINES_W (ROW_AW)
  ) u_score (
    .Clk         (Clk),
    .Reset       (Reset),
    .clear_score (clear_score),
    .update_en   (done),
    .lines       (cnt_q),
    .score       (score)
  );

endmodule

// File: tb/tb_row_clear_controller.sv
// Bench for row_clear_controller: behavioural board storage, expected pass
// results queued at start and compared once the pass completes.
module tb_row_clear_controller;

  localparam int NR = 20;

  logic       Clk;
  logic       Reset;
  logic       start;
  logic       clear_score;
  logic [4:0] rd_row;
  logic [7:0] rd_data;
  logic       wr_en;
  logic [4:0] wr_row;
  logic [7:0] wr_data;
  logic       busy;
  logic       done;
  logic [4:0] lines_cleared;
  logic [7:0] score;

  row_clear_controller dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .start         (start),
    .clear_score   (clear_score),
    .rd_row        (rd_row),
    .rd_data       (rd_data),
    .wr_en         (wr_en),
    .wr_row        (wr_row),
    .wr_data       (wr_data),
    .busy          (busy),
    .done          (done),
    .lines_cleared (lines_cleared),
    .score         (score)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [7:0] board    [NR];
  logic [7:0] load_img [NR];
  logic       load_req;

  assign rd_data = (rd_row < 5'd20) ? board[rd_row] : 8'h00;

  always @(posedge Clk) begin
    if (load_req) begin
      for (int i = 0; i < NR; i++) board[i] <= load_img[i];
    end else if (wr_en && wr_row < 5'd20) begin
      board[wr_row] <= wr_data;
    end
  end

  typedef struct packed {
    logic [4:0]   lines;
    logic [7:0]   score;
    logic [6:0]   lat;
    logic [5:0]   writes;
    logic [159:0] brd;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   sc_model = 0;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic int inc_for(input int k);
    if (k >= 4) return 8;
    if (k == 3) return 5;
    if (k == 2) return 3;
    return k;
  endfunction

  function automatic logic [159:0] pack_board();
    logic [159:0] r;
    for (int i = 0; i < NR; i++) r[i*8 +: 8] = board[i];
    return r;
  endfunction

  task automatic load_board();
    @(negedge Clk);
    load_req = 1'b1;
    @(negedge Clk);
    load_req = 1'b0;
  endtask

  task automatic push_expected(input bit clr_in_done);
    exp_t e;
    int   k, n, wrs;
    k = 0; n = 0; wrs = 0;
    e.brd = '0;
    for (int i = 0; i < NR; i++) begin
      if (load_img[i] == 8'hFF) begin
        k++;
      end else begin
        if (n != i) wrs++;
        e.brd[n*8 +: 8] = load_img[i];
        n++;
      end
    end
    wrs += k;
    sc_model = clr_in_done ? 0 : ((sc_model + inc_for(k) > 255) ? 255 : sc_model + inc_for(k));
    e.lines  = 5'(k);
    e.score  = 8'(sc_model);
    e.lat    = 7'(NR + k + 1);
    e.writes = 6'(wrs);
    sb_q.push_back(e);
  endtask

  task automatic run_pass(input string tag, input int repulse_at, input bit clr_in_done);
    exp_t e;
    int   cyc, dones, wrs, done_cyc;
    logic [4:0] got_lines;
    logic [7:0] got_score;
    load_board();
    push_expected(clr_in_done);
    @(negedge Clk);
    start = 1'b1;
    cyc = 0; dones = 0; wrs = 0; done_cyc = -1;
    got_lines = '0; got_score = '0;
    while (cyc < 80 && !(done_cyc >= 0 && cyc >= done_cyc + 3)) begin
      @(negedge Clk);
      cyc++;
      start = (cyc == repulse_at);
      clear_score = 1'b0;
      if (wr_en) wrs++;
      if (done) begin
        dones++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          clear_score = clr_in_done;
        end
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        got_lines = lines_cleared;
        got_score = score;
      end
    end
    start = 1'b0;
    clear_score = 1'b0;
    if (done_cyc < 0) check({tag, "_done_timeout"}, 0, 1);
    e = sb_q.pop_front();
    check({tag, "_done_cycle"}, done_cyc, e.lat);
    check({tag, "_done_count"}, dones, 1);
    check({tag, "_lines"}, got_lines, e.lines);
    check({tag, "_score"}, got_score, e.score);
    check({tag, "_writes"}, wrs, e.writes);
    check({tag, "_board"}, pack_board(), e.brd);
    check({tag, "_busy_end"}, busy, 0);
  endtask

  task automatic img_four();
    for (int i = 0; i < NR; i++) load_img[i] = (i >= 3 && i <= 6) ? 8'hFF : 8'h5A;
  endtask

  task automatic img_one();
    load_img[0] = 8'hFF;
    for (int i = 1; i < NR; i++) load_img[i] = 8'(i);
  endtask

  initial begin
    Reset = 1'b0; start = 1'b0; clear_score = 1'b0; load_req = 1'b0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_rd_row", rd_row, 0);
    check("rst_wr_row", wr_row, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_lines", lines_cleared, 0);
    check("rst_score", score, 0);
    @(negedge Clk);
    Reset = 1'b1;

    for (int i = 0; i < NR; i++) load_img[i] = 8'h00;
    run_pass("empty", -1, 0);
    img_one();
    run_pass("one_line", -1, 0);
    img_four();
    run_pass("four_lines", -1, 0);

    @(negedge Clk);
    clear_score = 1'b1;
    @(negedge Clk);
    clear_score = 1'b0;
    sc_model = 0;
    check("idle_clear_score", score, 0);

    for (int n = 0; n < 31; n++) begin
      img_four();
      run_pass("pre4", -1, 0);
    end
    for (int n = 0; n < 2; n++) begin
      img_one();
      run_pass("pre1", -1, 0);
    end
    check("preload_250", score, 250);
    img_four();
    run_pass("saturate", -1, 0);
    check("saturate_255", score, 255);
    img_four();
    run_pass("clr_in_done", -1, 1);

    img_one();
    run_pass("repulse", 6, 0);

    for (int i = 0; i < NR; i++) load_img[i] = 8'hFF;
    run_pass("all_full", -1, 0);
    for (int i = 0; i < NR; i++) load_img[i] = (i == 0 || i == NR - 1) ? 8'hFF : 8'(8'h30 + i);
    run_pass("edge_rows", -1, 0);

    img_one();
    load_board();
    @(negedge Clk);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    repeat (3) @(negedge Clk);
    check("pre_rst_busy", busy, 1);
    check("pre_rst_wr_en", wr_en, 1);
    check("pre_rst_score", score, 8'(sc_model));
    #2 Reset = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_wr_en", wr_en, 0);
    check("mid_rst_score", score, 0);
    check("mid_rst_done", done, 0);
    @(negedge Clk);
    Reset = 1'b1;
    sc_model = 0;
    img_four();
    run_pass("post_rst", -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
